// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, the hardwired-zero address and the address type
package reg_file_pkg;
    localparam int W_DEF  = 8;
    localparam int D_DEF  = 4;
    localparam int NR_DEF = 2;
    typedef logic [D_DEF-1:0] reg_addr_t;
    localparam reg_addr_t REG0 = '0;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read mux with write bypass and busy masking
// Ports: raddr_i address; regs_i/busy_i storage and scoreboard; we*/waddr*/wdata*
// the in-flight writes; rdata_o read data; rbusy_o busy flag of the addressed register.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int D       = D_DEF,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic [D-1:0]            raddr_i,
    input  logic [2**D-1:0][W-1:0]  regs_i,
    input  logic [2**D-1:0]         busy_i,
    input  logic                    we0_i,
    input  logic [D-1:0]            waddr0_i,
    input  logic [W-1:0]            wdata0_i,
    input  logic                    we1_i,
    input  logic [D-1:0]            waddr1_i,
    input  logic [W-1:0]            wdata1_i,
    output logic [W-1:0]            rdata_o,
    output logic                    rbusy_o
);
    logic is_zero, hit0, hit1;
    assign is_zero = ZERO_R0 && raddr_i == D'(REG0);
    assign hit0    = BYPASS && we0_i && waddr0_i == raddr_i;
    assign hit1    = BYPASS && we1_i && waddr1_i == raddr_i;
    // port 1 has priority on a double hit, matching the write arbitration
    assign rdata_o = is_zero ? '0 : hit1 ? wdata1_i : hit0 ? wdata0_i : regs_i[raddr_i];
    // a forwarded value is the finished result, so its producer is no longer pending
    assign rbusy_o = !is_zero && !(hit0 || hit1) && busy_i[raddr_i];
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports and a busy scoreboard
// Ports: clk_i/reset_i clock and async active-high reset; raddr_i/rdata_o/rbusy_o packed
// read ports; we0/waddr0/wdata0 ALU write; we1/waddr1/wdata1 load writeback write;
// busy_set_i/busy_addr_i issue-side pending mark; wcollide_o one-cycle same-address write pulse.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int D       = D_DEF,
    parameter int NR      = NR_DEF,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NR*D-1:0] raddr_i,
    output logic [NR*W-1:0] rdata_o,
    output logic [NR-1:0]   rbusy_o,
    input  logic            we0_i,
    input  logic [D-1:0]    waddr0_i,
    input  logic [W-1:0]    wdata0_i,
    input  logic            we1_i,
    input  logic [D-1:0]    waddr1_i,
    input  logic [W-1:0]    wdata1_i,
    input  logic            busy_set_i,
    input  logic [D-1:0]    busy_addr_i,
    output logic            wcollide_o
);
    localparam int N = 2**D;
    if (NR < 1 || NR > 4) begin : g_nr_check
        $error("reg_file_mp: NR must be in 1..4");
    end
    logic [N-1:0][W-1:0] regs_q, regs_d;
    logic [N-1:0]        busy_q, busy_d;
    logic                wcollide_q, wcollide_d;
    logic                w0_ok, w1_ok, bs_ok;
    assign w0_ok = we0_i && !(ZERO_R0 && waddr0_i == D'(REG0));
    assign w1_ok = we1_i && !(ZERO_R0 && waddr1_i == D'(REG0));
    assign bs_ok = busy_set_i && !(ZERO_R0 && busy_addr_i == D'(REG0));
    // the collision pulse ignores the R0 guard: it reports the request, not the effect
    assign wcollide_d = we0_i && we1_i && waddr0_i == waddr1_i;
    // assignment order encodes priority: port 1 over port 0, busy set over clear
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (w0_ok) regs_d[waddr0_i] = wdata0_i;
        if (w1_ok) regs_d[waddr1_i] = wdata1_i;
        if (we0_i) busy_d[waddr0_i] = 1'b0;
        if (we1_i) busy_d[waddr1_i] = 1'b0;
        if (bs_ok) busy_d[busy_addr_i] = 1'b1;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            regs_q     <= '0;
            busy_q     <= '0;
            wcollide_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            wcollide_q <= wcollide_d;
        end
    end
    assign wcollide_o = wcollide_q;
    for (genvar i = 0; i < NR; i++) begin : g_rd
        rf_read_port #(.W(W), .D(D), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_rd (
            .raddr_i  (raddr_i[i*D +: D]),
            .regs_i   (regs_q),
            .busy_i   (busy_q),
            .we0_i    (we0_i),
            .waddr0_i (waddr0_i),
            .wdata0_i (wdata0_i),
            .we1_i    (we1_i),
            .waddr1_i (waddr1_i),
            .wdata1_i (wdata1_i),
            .rdata_o  (rdata_o[i*W +: W]),
            .rbusy_o  (rbusy_o[i])
        );
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed vector table, async reset sequence and random run against a model
module tb_reg_file_mp;
    localparam int W = 8, D = 4, NR = 2;
    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [NR*D-1:0] raddr_i;
    logic [NR*W-1:0] rdata_o;
    logic [NR-1:0]   rbusy_o;
    logic            we0_i, we1_i, busy_set_i;
    logic [D-1:0]    waddr0_i, waddr1_i, busy_addr_i;
    logic [W-1:0]    wdata0_i, wdata1_i;
    logic            wcollide_o;
    int n_cmp = 0, n_err = 0;
    int mem[16];
    int bsy[16];
    int col;
    typedef struct {
        int we0, wa0, wd0, we1, wa1, wd1, bs, ba, ra0, ra1, rd0, rd1, rb0, rb1, wc;
    } vec_t;
    vec_t tv[22];
    reg_file_mp #(.W(W), .D(D), .NR(NR), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .rbusy_o(rbusy_o), .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
        .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
        .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i), .wcollide_o(wcollide_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(string nm, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask
    task automatic drive(int we0, int wa0, int wd0, int we1, int wa1, int wd1,
                         int bs, int ba, int ra0, int ra1);
        we0_i = 1'(we0); waddr0_i = 4'(wa0); wdata0_i = 8'(wd0);
        we1_i = 1'(we1); waddr1_i = 4'(wa1); wdata1_i = 8'(wd1);
        busy_set_i = 1'(bs); busy_addr_i = 4'(ba);
        raddr_i = {4'(ra1), 4'(ra0)};
    endtask
    // reference: a same-cycle write is visible to reads; port 1 is the later writer
    function automatic int m_rd(int a);
        if (a == 0) return 0;
        if (we1_i && int'(waddr1_i) == a) return int'(wdata1_i);
        if (we0_i && int'(waddr0_i) == a) return int'(wdata0_i);
        return mem[a];
    endfunction
    function automatic int m_rb(int a);
        if (a == 0) return 0;
        if ((we1_i && int'(waddr1_i) == a) || (we0_i && int'(waddr0_i) == a)) return 0;
        return bsy[a];
    endfunction
    task automatic m_clear();
        for (int k = 0; k < 16; k++) begin mem[k] = 0; bsy[k] = 0; end
        col = 0;
    endtask
    task automatic m_edge();
        int nc;
        nc = (we0_i && we1_i && waddr0_i == waddr1_i) ? 1 : 0;
        for (int a = 1; a < 16; a++) begin
            if (we0_i && int'(waddr0_i) == a) begin mem[a] = int'(wdata0_i); bsy[a] = 0; end
            if (we1_i && int'(waddr1_i) == a) begin mem[a] = int'(wdata1_i); bsy[a] = 0; end
            if (busy_set_i && int'(busy_addr_i) == a) bsy[a] = 1;
        end
        col = nc;
    endtask
    task automatic cyc();
        @(posedge clk_i);
        m_edge();
        @(negedge clk_i);
    endtask
    task automatic chk_model(string tag);
        for (int p = 0; p < NR; p++) begin
            chk({tag, "_rdata"}, int'(rdata_o[p*W +: W]), m_rd(int'(raddr_i[p*D +: D])));
            chk({tag, "_rbusy"}, int'(rbusy_o[p]), m_rb(int'(raddr_i[p*D +: D])));
        end
        chk({tag, "_wcollide"}, int'(wcollide_o), col);
    endtask
    initial begin
        tv = '{
            '{1,3,'hA5,0,0,0,   0,0,3,0,'hA5,0,    0,0,0},
            '{0,0,0,0,0,0,      0,0,3,0,'hA5,0,    0,0,0},
            '{1,5,'h11,1,5,'h22,0,0,5,3,'h22,'hA5, 0,0,0},
            '{0,0,0,0,0,0,      0,0,5,5,'h22,'h22, 0,0,1},
            '{0,0,0,0,0,0,      0,0,5,3,'h22,'hA5, 0,0,0},
            '{1,7,'h10,0,0,0,   0,0,7,3,'h10,'hA5, 0,0,0},
            '{0,0,0,1,7,'h3C,   0,0,7,7,'h3C,'h3C, 0,0,0},
            '{0,0,0,0,0,0,      0,0,7,5,'h3C,'h22, 0,0,0},
            '{0,0,0,0,0,0,      1,9,9,7,0,'h3C,    0,0,0},
            '{0,0,0,0,0,0,      0,0,9,9,0,0,       1,1,0},
            '{1,9,'h44,0,0,0,   1,9,9,3,'h44,'hA5, 0,0,0},
            '{0,0,0,0,0,0,      0,0,9,9,'h44,'h44, 1,1,0},
            '{0,0,0,1,9,'h55,   0,0,9,9,'h55,'h55, 0,0,0},
            '{0,0,0,0,0,0,      0,0,9,3,'h55,'hA5, 0,0,0},
            '{1,0,'hFF,0,0,0,   1,0,0,0,0,0,       0,0,0},
            '{0,0,0,0,0,0,      0,0,0,9,0,'h55,    0,0,0},
            '{1,0,'h01,1,0,'h02,0,0,0,5,0,'h22,    0,0,0},
            '{0,0,0,0,0,0,      0,0,0,5,0,'h22,    0,0,1},
            '{1,1,'h12,1,2,'h34,0,0,1,2,'h12,'h34, 0,0,0},
            '{0,0,0,0,0,0,      0,0,1,2,'h12,'h34, 0,0,0},
            '{0,0,0,0,0,0,      1,4,4,5,0,'h22,    0,0,0},
            '{0,0,0,0,0,0,      0,0,4,4,0,0,       1,1,0}
        };
        reset_i = 1'b1;
        drive(0,0,0,0,0,0,0,0,3,5);
        m_clear();
        #1;
        chk("reset_rdata", int'(rdata_o), 0);
        chk("reset_rbusy", int'(rbusy_o), 0);
        chk("reset_wcollide", int'(wcollide_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        foreach (tv[i]) begin
            drive(tv[i].we0, tv[i].wa0, tv[i].wd0, tv[i].we1, tv[i].wa1, tv[i].wd1,
                  tv[i].bs, tv[i].ba, tv[i].ra0, tv[i].ra1);
            #1;
            chk($sformatf("vec%0d_rdata0", i), int'(rdata_o[7:0]), tv[i].rd0);
            chk($sformatf("vec%0d_rdata1", i), int'(rdata_o[15:8]), tv[i].rd1);
            chk($sformatf("vec%0d_rbusy0", i), int'(rbusy_o[0]), tv[i].rb0);
            chk($sformatf("vec%0d_rbusy1", i), int'(rbusy_o[1]), tv[i].rb1);
            chk($sformatf("vec%0d_wcollide", i), int'(wcollide_o), tv[i].wc);
            cyc();
        end
        for (int a = 1; a < 16; a++) begin
            drive(1, a, a * 16 + a, 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        drive(1, 6, 'h61, 1, 6, 'h66, 1, 4, 0, 0);
        cyc();
        drive(1, 2, 'h99, 0, 0, 0, 0, 0, 4, 6);
        #1;
        chk_model("prerst");
        #1;
        reset_i = 1'b1;
        #1;
        chk("rst_async_wcollide", int'(wcollide_o), 0);
        chk("rst_async_rbusy4", int'(rbusy_o[0]), 0);
        chk("rst_async_rdata6", int'(rdata_o[15:8]), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, a, 15 - a);
            #1;
            chk($sformatf("rst_rdata_a%0d", a), int'(rdata_o), 0);
            chk($sformatf("rst_rbusy_a%0d", a), int'(rbusy_o), 0);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        m_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 4);
        #1;
        chk("rst_abort_write_r2", int'(rdata_o[7:0]), 0);
        chk_model("postrst");
        cyc();
        for (int n = 0; n < 400; n++) begin
            int wa0, wa1;
            wa0 = $urandom_range(0, 15);
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : $urandom_range(0, 15);
            drive($urandom_range(0, 1), wa0, $urandom_range(0, 255),
                  $urandom_range(0, 1), wa1, $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 1) ? wa0 : $urandom_range(0, 15),
                  $urandom_range(0, 1) ? wa1 : $urandom_range(0, 15));
            #1;
            chk_model("rnd");
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined datapath, replacing the 2-read/1-write file.
- Provides NR combinational read ports and two clocked write ports: port 0 for the ALU, port 1 for load writeback.
- Optional R0-hardwired-zero and optional write-to-read bypass.
- Per-register busy scoreboard: issue logic marks a destination pending; writeback clears it.

Parameters:
- W, 8, data path width in bits.
- D, 4, address width; register count is 2**D.
- NR, 2, number of read ports (1..4).
- ZERO_R0, 1, 1 = register 0 always reads 0; writes and busy-set to it are ignored.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- raddr  in  NR*D  packed read addresses; port i = raddr[i*D +: D].
- rdata  out  NR*W  packed read data; port i = rdata[i*W +: W].
- rbusy  out  NR  busy flag of the register addressed by each read port.
- we0  in  1  write enable, port 0.
- waddr0  in  D  write address, port 0.
- wdata0  in  W  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  D  write address, port 1.
- wdata1  in  W  write data, port 1.
- busy_set  in  1  mark busy_addr pending.
- busy_addr  in  D  register to mark pending.
- wcollide  out  1  registered pulse: both write ports targeted the same address last cycle.

Behaviour:
- Reset is asynchronous and active-high. While reset = 1: all registers = 0, all busy bits = 0, wcollide = 0. Reset asserted mid-operation aborts any pending write.
- Reads are combinational with 0-cycle latency; rdata[i] = registers[raddr[i]].
- ZERO_R0 = 1:
  - Address 0 reads 0 and rbusy = 0.
  - Writes to address 0 are dropped.
  - busy_set with busy_addr = 0 is ignored.
- Writes take effect at the rising CLK edge.
  - If we0 and we1 target the same address, port 1 wins, and wcollide = 1 for exactly the next cycle.
  - A collision at address 0 with ZERO_R0 = 1 still pulses wcollide.
- BYPASS = 1, read address matches an enabled write this cycle (address 0 excluded when ZERO_R0 = 1):
  - rdata returns the write data; if both ports match, port 1's data.
  - rbusy reads 0 for that address.
- BYPASS = 0: reads return the pre-edge value, and rbusy reflects the current busy bit.
- Busy scoreboard, updated at the rising edge:
  - A write on either port to address a clears busy[a].
  - busy_set sets busy[busy_addr].
  - Simultaneous set and clear of the same address: set wins (a new producer has been issued).
- Multiple read ports may address the same register; there is no arbitration.
- Width rules: there is no arithmetic. Packed port slicing is fixed by NR, D and W. Out-of-range NR (0 or > 4) is a compile-time error raised by an elaboration-time check.

Decomposition:
- Shared package reg_file_pkg: the default W/D/NR constants, the REG0 address constant, and a reg_addr_t typedef (logic [D-1:0] at the default D).
- One natural sub-module, rf_read_port: a single read mux with bypass compare and busy masking, instantiated NR times in a generate loop.
- Storage, write arbitration, the scoreboard and the collision register stay in reg_file_mp.

Test Plan (W=8, D=4, NR=2, ZERO_R0=1, BYPASS=1):
- Write/read:
  - Stimulus: we0 = 1, waddr0 = 3, wdata0 = 8'hA5 for one cycle; then raddr port0 = 3, port1 = 0.
  - Response: rdata0 = A5, rdata1 = 00.
- Collision:
  - Stimulus: we0 = 1 (waddr0 = 5, wdata0 = 11) and we1 = 1 (waddr1 = 5, wdata1 = 22) in the same cycle.
  - Response: register 5 = 22; wcollide = 1 for exactly one cycle, then 0.
- Bypass:
  - Stimulus: register 7 = 10; in the same cycle, we1 = 1, waddr1 = 7, wdata1 = 3C with raddr port0 = 7.
  - Response: rdata0 = 3C combinationally before the edge.
- Scoreboard:
  - Stimulus: busy_set = 1, busy_addr = 9, then idle.
  - Response: rbusy = 1 on a port reading 9.
  - Stimulus: we0 = 1, waddr0 = 9 while busy_set = 1, busy_addr = 9 in the same cycle.
  - Response: busy[9] stays 1.
  - Stimulus: a later write to 9 with busy_set = 0.
  - Response: rbusy = 0 during the write cycle (bypass) and after.
- R0 guard:
  - Stimulus: we0 = 1, waddr0 = 0, wdata0 = FF; busy_set with busy_addr = 0.
  - Response: reads of 0 return 00 with rbusy = 0.
- Async reset:
  - Stimulus: registers 1..15 = nonzero and busy[4] = 1; assert reset between clock edges.
  - Response: all rdata = 0, rbusy = 0 and wcollide = 0 immediately, without waiting for a clock edge.
